// File: rtl/maple_in.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | maple_in : Maple bus receiver (START/data/END decode, byte push)      |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module maple_in #(
  parameter int TIMEOUT_TICKS = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       enable,
  input  logic       in_p1,
  input  logic       in_p5,
  input  logic       fifo_ready,
  output logic [7:0] fifo_data,
  output logic       fifo_produce,
  output logic       busy,
  output logic       frame_start,
  output logic       frame_end,
  output logic       err_framing,
  output logic       err_overflow,
  output logic       err_timeout,
  input  logic       clear_errors
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_END   = 2'd3;

  logic [1:0] sync_p1, sync_p5;
  logic       prev_p1, prev_p5;
  logic       cur_p1, cur_p5;
  logic       fall_p1, fall_p5, rise_p1, rise_p5;

  logic [1:0] state;
  logic [2:0] start_cnt;
  logic [2:0] bit_cnt;
  logic       phase_b;
  logic [6:0] shift;
  logic [7:0] to_cnt;

  logic       set_framing, set_overflow, set_timeout;
  logic       data_edge, data_bit, byte_done;

  assign cur_p1  = sync_p1[1];
  assign cur_p5  = sync_p5[1];
  assign fall_p1 = prev_p1 & ~cur_p1;
  assign fall_p5 = prev_p5 & ~cur_p5;
  assign rise_p1 = ~prev_p1 & cur_p1;
  assign rise_p5 = ~prev_p5 & cur_p5;
  assign busy    = (state != ST_IDLE);

  // Synchronizers reset to 1 so the idle bus produces no edge after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p1 <= 2'b11;
      sync_p5 <= 2'b11;
      prev_p1 <= 1'b1;
      prev_p5 <= 1'b1;
    end else begin
      sync_p1 <= {sync_p1[0], in_p1};
      sync_p5 <= {sync_p5[0], in_p5};
      prev_p1 <= cur_p1;
      prev_p5 <= cur_p5;
    end
  end

  always_comb begin
    set_framing = 1'b0;
    set_timeout = 1'b0;
    data_edge   = 1'b0;
    data_bit    = 1'b0;
    if (enable && state != ST_IDLE) begin
      if (to_cnt == 8'(TIMEOUT_TICKS)) begin
        set_timeout = 1'b1;
      end else begin
        case (state)
          ST_START: if (rise_p1 && start_cnt != 3'd4) set_framing = 1'b1;
          ST_DATA: begin
            if (fall_p1 && fall_p5) begin
              set_framing = 1'b1;
            end else if (!phase_b) begin
              if (fall_p5) set_framing = 1'b1;
              else if (fall_p1) begin
                data_edge = 1'b1;
                data_bit  = cur_p5;
              end
            end else begin
              // A p1 clock in phase B is only legal as the END marker
              if (fall_p1 && bit_cnt != 3'd1) set_framing = 1'b1;
              else if (fall_p5) begin
                data_edge = 1'b1;
                data_bit  = cur_p1;
              end
            end
          end
          ST_END: if (fall_p5) set_framing = 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign byte_done    = data_edge && (bit_cnt == 3'd7);
  assign set_overflow = byte_done && !fifo_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      start_cnt    <= 3'd0;
      bit_cnt      <= 3'd0;
      phase_b      <= 1'b0;
      shift        <= 7'd0;
      to_cnt       <= 8'd0;
      fifo_data    <= 8'd0;
      fifo_produce <= 1'b0;
      frame_start  <= 1'b0;
      frame_end    <= 1'b0;
      err_framing  <= 1'b0;
      err_overflow <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      fifo_produce <= 1'b0;
      frame_start  <= 1'b0;
      frame_end    <= 1'b0;
      err_framing  <= set_framing  | (err_framing  & ~clear_errors);
      err_overflow <= set_overflow | (err_overflow & ~clear_errors);
      err_timeout  <= set_timeout  | (err_timeout  & ~clear_errors);

      if (state == ST_IDLE || fall_p1 || fall_p5 || rise_p1 || rise_p5)
        to_cnt <= 8'd0;
      else if (tick)
        to_cnt <= to_cnt + 8'd1;

      if (!enable || set_timeout || set_framing) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (fall_p1 && cur_p5) begin
              state     <= ST_START;
              start_cnt <= 3'd0;
            end
          end
          ST_START: begin
            if (rise_p1) begin
              frame_start <= 1'b1;
              state       <= ST_DATA;
              phase_b     <= 1'b0;
              bit_cnt     <= 3'd0;
              shift       <= 7'd0;
            end else if (fall_p5 && !cur_p1 && start_cnt != 3'd7) begin
              start_cnt <= start_cnt + 3'd1;
            end
          end
          ST_DATA: begin
            if (data_edge) begin
              shift   <= {shift[5:0], data_bit};
              bit_cnt <= bit_cnt + 3'd1;
              phase_b <= ~phase_b;
              if (byte_done) begin
                fifo_data    <= {shift, data_bit};
                fifo_produce <= fifo_ready;
              end
            end else if (phase_b && fall_p1) begin
              state <= ST_END;
            end
          end
          ST_END: begin
            if (rise_p5 && cur_p1) begin
              frame_end <= 1'b1;
              state     <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
